// File: rtl/apb_lsram_arbiter.sv
// apb_lsram_arbiter
//   Round-robin arbiter for two single-word requesters in front of an APB3
//   master sequencer. It drives the filterwheel LSRAM slave, which has a
//   16-bit data path and 2048 words.
//
//   Requester side (n = 0/1):
//     REQn/WRn/ADDRn/WDATAn : request, held until ACKn
//     ACKn                  : one-cycle completion pulse
//     ERRn                  : pulses with ACKn on PSLVERR or wait-state timeout
//     RDATAn                : read data, held until that requester's next ACK
//   APB side:
//     M_PSEL/M_PENABLE/M_PWRITE/M_PADDR/M_PWDATA : registered master outputs
//     M_PRDATA/M_PREADY/M_PSLVERR               : slave response
//   BUSY : high whenever the sequencer is not IDLE
module apb_lsram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DWIDTH     = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  REQ0,
  input  logic                  WR0,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [DWIDTH-1:0]     WDATA0,
  output logic                  ACK0,
  output logic [DWIDTH-1:0]     RDATA0,
  output logic                  ERR0,
  input  logic                  REQ1,
  input  logic                  WR1,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DWIDTH-1:0]     WDATA1,
  output logic                  ACK1,
  output logic [DWIDTH-1:0]     RDATA1,
  output logic                  ERR1,
  output logic                  M_PSEL,
  output logic                  M_PENABLE,
  output logic                  M_PWRITE,
  output logic [19:0]           M_PADDR,
  output logic [DWIDTH-1:0]     M_PWDATA,
  input  logic [DWIDTH-1:0]     M_PRDATA,
  input  logic                  M_PREADY,
  input  logic                  M_PSLVERR,
  output logic                  BUSY
);

  localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int PAD = 19 - ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  grant_q, grant_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0]     wdata_q, wdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic [DWIDTH-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  busy_q, busy_d;

  logic                  win_s;
  logic                  fin_s;
  logic                  fail_s;
  logic [DWIDTH-1:0]     rd_s;
  logic                  timeout_hit_s;

  // This is the last PREADY-low cycle allowed. A TIMEOUT of 0 never fires.
  assign timeout_hit_s = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    win_s     = 1'b0;
    fin_s     = 1'b0;
    fail_s    = 1'b0;
    rd_s      = {DWIDTH{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          // On a tie, the requester not served last wins.
          if (REQ0 && REQ1) begin
            win_s = ~last_q;
          end else begin
            win_s = REQ1;
          end
          grant_d = win_s;
          last_d  = win_s;
          wr_d    = win_s ? WR1 : WR0;
          addr_d  = win_s ? ADDR1 : ADDR0;
          wdata_d = win_s ? WDATA1 : WDATA0;
          psel_d  = 1'b1;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = {CW{1'b0}};
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (M_PREADY) begin
          fin_s  = 1'b1;
          fail_s = M_PSLVERR;
          rd_s   = M_PRDATA;
        end else if (timeout_hit_s) begin
          fin_s  = 1'b1;
          fail_s = 1'b1;
          rd_s   = {DWIDTH{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (fin_s) begin
          state_d   = S_DONE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          // Writes, including failed ones, leave read data untouched.
          if (grant_q) begin
            ack1_d = 1'b1;
            err1_d = fail_s;
            if (!wr_q) begin
              rdata1_d = rd_s;
            end else begin
              rdata1_d = rdata1_q;
            end
          end else begin
            ack0_d = 1'b1;
            err0_d = fail_s;
            if (!wr_q) begin
              rdata0_d = rd_s;
            end else begin
              rdata0_d = rdata0_q;
            end
          end
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops PSEL/PENABLE immediately
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= {ADDR_WIDTH{1'b0}};
      wdata_q   <= {DWIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= {DWIDTH{1'b0}};
      rdata1_q  <= {DWIDTH{1'b0}};
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      busy_q    <= busy_d;
    end
  end

  assign ACK0      = ack0_q;
  assign ACK1      = ack1_q;
  assign ERR0      = err0_q;
  assign ERR1      = err1_q;
  assign RDATA0    = rdata0_q;
  assign RDATA1    = rdata1_q;
  assign M_PSEL    = psel_q;
  assign M_PENABLE = penable_q;
  assign M_PWRITE  = wr_q;
  assign M_PADDR   = {{PAD{1'b0}}, addr_q, 1'b0};
  assign M_PWDATA  = wdata_q;
  assign BUSY      = busy_q;

endmodule

// File: doc/apb_lsram_arbiter.md
# apb_lsram_arbiter

Two-requester arbiter and APB3 master sequencer for the filterwheel APB LSRAM slave (16-bit data, 2048 words). Each requester issues single-word read/write transactions over a simple REQ/ACK handshake. The arbiter grants them round-robin and runs the APB SETUP/ACCESS phases. It honours PREADY wait states and reports PSLVERR or a wait-state timeout back to the requester that issued the transfer.

## Interface
- ADDR_WIDTH, 11, requester word-address width (2048 locations)
- DWIDTH, 16, data width; matches the slave APB data width
- TIMEOUT, 255, maximum ACCESS cycles allowed with PREADY low; 0 disables the timeout

- PCLK  in  1  clock; all logic on the rising edge
- PRESETN  in  1  asynchronous active-low reset
- REQ0 / REQ1  in  1  transaction request; held high until ACK
- WR0 / WR1  in  1  1 = write, 0 = read; held stable with REQ
- ADDR0 / ADDR1  in  ADDR_WIDTH  word address; held stable with REQ
- WDATA0 / WDATA1  in  DWIDTH  write data; held stable with REQ
- ACK0 / ACK1  out  1  one-cycle completion pulse
- RDATA0 / RDATA1  out  DWIDTH  read data; valid from the ACK cycle and held until that requester's next ACK
- ERR0 / ERR1  out  1  pulses together with ACK when the transfer failed (PSLVERR or timeout)
- M_PSEL, M_PENABLE, M_PWRITE  out  1  APB master controls
- M_PADDR  out  20  byte address = {zero-extend, granted ADDR, 1'b0}
- M_PWDATA  out  DWIDTH  latched write data
- M_PRDATA  in  DWIDTH  slave read data
- M_PREADY, M_PSLVERR  in  1  slave ready and error
- BUSY  out  1  high in every state except IDLE

## Operation
- FSM states:
  - IDLE: no APB activity. If any REQ is high at the clock edge, choose a winner, latch its WR/ADDR/WDATA, record the grant, and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0. Always lasts exactly one cycle, then go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. Stay here while PREADY=0.
    - On PREADY=1: capture PRDATA (reads only) and PSLVERR, then go to DONE.
    - On timeout: force the error, set the read data to 0, and go to DONE.
  - DONE: drop PSEL and PENABLE. ACKn=1 for the granted requester. ERRn=captured error. Then go to IDLE.
- Arbitration:
  - A single requester is granted immediately.
  - When both request, the winner is the requester not recorded in LAST.
  - LAST is updated at each grant. Its reset value is 1, so requester 0 wins the first tie.
- Address, data and direction are latched at grant. Changes to the requester inputs after grant have no effect.
- A REQ dropped before grant produces no transfer. A REQ dropped after grant still completes the transfer and still pulses ACK.
- Requester rule: drop REQ on the clock edge that sees ACK. REQ still high in the following IDLE cycle counts as a new request.
- Writes leave RDATAn unchanged. Error writes pulse ERR only.
- The timeout counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT, the transfer terminates with an error.

## Timing
- Reset: all outputs are 0, FSM is in IDLE, LAST=1, timeout counter=0.
- Zero-wait-state transfer takes 4 cycles: IDLE (REQ sampled), SETUP, ACCESS (PREADY=1), DONE (ACK).
- Minimum spacing between transfer starts is 4 cycles.
- Each PREADY=0 cycle in ACCESS adds one cycle of latency.
- A timed-out transfer ACKs on the cycle after ACCESS cycle number TIMEOUT.
- M_PADDR, M_PWRITE and M_PWDATA are stable from SETUP through the end of ACCESS, per APB3.
- Only one ACK is asserted in any cycle. ACK0 and ACK1 are never high together.
- PRESETN asserted mid-transfer: PSEL and PENABLE drop asynchronously, no ACK or ERR is issued, the transfer is lost, and the state returns to IDLE.

## Test plan
- Write then read: REQ0 writes 0xA5C3 to address 0x7FF, then REQ0 reads 0x7FF.
  - M_PADDR must be 0x00FFE.
  - ACK0 must occur on the 4th cycle of each transfer.
  - RDATA0 must be 0xA5C3, with ERR0=0.
- Simultaneous requests: REQ0 and REQ1 rise together from reset, both reading, and both are held continuously.
  - Grants must be 0, 1, 0, 1.
  - No ACK overlap.
  - Each ACK spaced 4 cycles apart.
- Wait states: slave holds PREADY low for 3 cycles on a read of 0x123.
  - ACK arrives on cycle 7.
  - PADDR, PWRITE and PWDATA are stable throughout ACCESS.
  - RDATA equals the PRDATA value present in the PREADY cycle.
- Slave error: PSLVERR=1 with PREADY on a write.
  - ACK1 and ERR1 pulse together.
  - RDATA1 is unchanged.
  - The next transfer has ERR=0.
- Timeout: TIMEOUT=4 and PREADY held low.
  - After 4 ACCESS cycles the transfer ends with ACK and ERR, RDATA=0.
  - BUSY is low the following cycle.
- Reset mid-ACCESS: assert PRESETN low in the middle of ACCESS.
  - M_PSEL falls without waiting for a clock edge.
  - No ACK is issued.
  - After release, a fresh REQ1 completes normally in 4 cycles.
